// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package instr_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  localparam int unsigned DEPTH_DEFAULT  = 128;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Little-endian byte-to-word packer: byte k of a word lands in bits [8k+7:8k].
// word_o is the word as it will look once the current byte is taken, so the
// caller can register a complete word on the same edge as the last byte.
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accept_i,
  input  logic        clear_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic        full_o
);

  logic [1:0]  cnt_q;
  logic [1:0]  cnt_d;
  logic [31:0] word_q;

  // Insert the incoming byte into the lane selected by the byte counter.
  always_comb begin
    word_o = word_q;
    unique case (cnt_q)
      2'd0:    word_o[7:0]   = data_i;
      2'd1:    word_o[15:8]  = data_i;
      2'd2:    word_o[23:16] = data_i;
      default: word_o[31:24] = data_i;
    endcase
    full_o = accept_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
    cnt_d  = cnt_q + 2'd1;
  end

  // Byte counter and partial word; clear discards any partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clear_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (accept_i) begin
      cnt_q  <= cnt_d;
      word_q <= word_o;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: streams bytes into 32-bit words and writes them to the
// instruction RAM, holding the core in reset until the load completes.
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEFAULT,
  parameter int unsigned ADDR_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [ADDR_W:0] len,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            byte_ready,
  output logic            we,
  output logic [31:0]     wa,
  output logic [31:0]     wd,
  output logic            busy,
  output logic            done,
  output logic            cores_hold
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] word_idx_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic              we_q;
  logic [31:0]       wa_q;
  logic [31:0]       wd_q;

  logic              accept;
  logic              start_ok;
  logic              start_empty;
  logic              last_word;
  logic              pk_clear;
  logic [31:0]       pk_word;
  logic              pk_full;

  // Handshake, start qualification and end-of-load detection.
  always_comb begin
    accept      = byte_valid && byte_ready;
    start_empty = start && (len == '0) && ((state_q == IDLE) || (state_q == DONE));
    start_ok    = start && (len != '0) && ((state_q == IDLE) || (state_q == DONE));
    last_word   = ({1'b0, word_idx_q} == (count_q - 1'b1));
    pk_clear    = start_ok || (state_q == WRITE);
    count_d     = (len > DEPTH_W) ? DEPTH_W : len;
  end

  byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .accept_i (accept),
    .clear_i  (pk_clear),
    .data_i   (byte_data),
    .word_o   (pk_word),
    .full_o   (pk_full)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_ok)         state_d = RECV;
        else if (start_empty) state_d = DONE;
      end
      RECV:  if (pk_full) state_d = WRITE;
      WRITE: state_d = last_word ? DONE : RECV;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    byte_ready = (state_q == RECV);
    busy       = (state_q == RECV) || (state_q == WRITE);
    done       = (state_q == DONE);
    cores_hold = (state_q != DONE);
  end

  // Word index, latched length and registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_idx_q <= '0;
      count_q    <= '0;
      we_q       <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
    end else begin
      we_q <= (state_q == RECV) && pk_full;
      if ((state_q == RECV) && pk_full) begin
        wa_q <= {{(32 - ADDR_W - 2){1'b0}}, word_idx_q, 2'b00};
        wd_q <= pk_word;
      end
      if (start_ok) begin
        word_idx_q <= '0;
        count_q    <= count_d;
      end else if ((state_q == WRITE) && !last_word) begin
        word_idx_q <= word_idx_q + 1'b1;
      end
    end
  end

  assign we = we_q;
  assign wa = wa_q;
  assign wd = wd_q;

endmodule
